// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   Serialises one parallel word per transfer into an asynchronous UART frame:
//   start bit (0), P_UART_DATA_WIDTH data bits LSB first, optional parity bit,
//   and P_UART_STOP_WIDTH stop bits (1). Every line bit lasts
//   BAUD_DIV = P_SYSTEM_CLK / P_UART_BUADRATE clocks. After reset release the
//   line is held idle for P_RST_CYCLE clocks before the first word is taken.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   i_user_tx_data   in   word to send (P_UART_DATA_WIDTH bits)
//   i_user_tx_valid  in   data-valid qualifier
//   o_user_tx_ready  out  high only in IDLE; transfer on valid && ready
//   o_uart_tx        out  serial line, idle high
//   o_tx_busy        out  frame in progress (START/DATA/PARITY/STOP)
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int P_SYSTEM_CLK      = 100_000_000,
    parameter int P_UART_BUADRATE   = 115200,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0,
    parameter int P_RST_CYCLE       = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                         i_user_tx_valid,
    output logic                         o_user_tx_ready,
    output logic                         o_uart_tx,
    output logic                         o_tx_busy
);

    localparam int BAUD_DIV = P_SYSTEM_CLK / P_UART_BUADRATE;

    // One counter serves both the bit-time and the post-reset hold, so it is
    // sized for whichever of the two is longer.
    localparam int CNT_MAX = (BAUD_DIV > P_RST_CYCLE) ? BAUD_DIV : P_RST_CYCLE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = 4;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    // A zero-length hold still spends one clock in RST_WAIT.
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'((P_RST_CYCLE > 0) ? P_RST_CYCLE - 1 : 0);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(P_UART_DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(P_UART_STOP_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_RST_WAIT,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [P_UART_DATA_WIDTH-1:0] shift_q;
    logic                         parity_q;
    logic                         bit_done;
    logic                         load;

    // Odd parity makes the total count of ones (data + parity) odd.
    function automatic logic calc_parity(input logic [P_UART_DATA_WIDTH-1:0] data);
        if (P_UART_CHECK == 1) begin
            return ~^data;
        end
        return ^data;
    endfunction

    assign bit_done = (cnt_q == BAUD_LAST);
    assign load     = (state_q == ST_IDLE) && i_user_tx_valid;

    // Control state: asynchronously reset so the line goes idle at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Word is captured at transfer so later input changes cannot disturb the
    // frame; the shift register drops one bit at the end of each data bit.
    always_ff @(posedge clock) begin
        if (load) begin
            shift_q  <= i_user_tx_data;
            parity_q <= calc_parity(i_user_tx_data);
        end else if ((state_q == ST_DATA) && bit_done) begin
            shift_q  <= shift_q >> 1;
        end
    end

    // Next-state logic; both counters restart on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        unique case (state_q)
            ST_RST_WAIT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (i_user_tx_valid) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        state_d = (P_UART_CHECK != 0) ? ST_PARITY : ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RST_WAIT;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs decode registered state only, so reset forces them immediately.
    always_comb begin
        o_uart_tx = 1'b1;
        unique case (state_q)
            ST_START:  o_uart_tx = 1'b0;
            ST_DATA:   o_uart_tx = shift_q[0];
            ST_PARITY: o_uart_tx = parity_q;
            default:   o_uart_tx = 1'b1;
        endcase
    end

    assign o_user_tx_ready = (state_q == ST_IDLE);
    assign o_tx_busy       = (state_q != ST_IDLE) && (state_q != ST_RST_WAIT);

endmodule
